neural_layer_engine: RTL and testbench
======================================

Name: neural_layer_engine

Overview:
Parametrised successor of the single-layer MAC accelerator: sequences one fully-connected layer of Nn neurons, each a signed dot product over Nk inputs. Drives read addresses for the weight ROM and neuron DP-RAM, accumulates through an internal pipelined MAC, and writes rescaled, saturated results back to the DP-RAM. Adds a start/busy/done handshake, runtime layer descriptor, fixed-point rescale, saturation and write-back, none of which the previous generation has.

Parameters:
DATA_W, 8, signed width of weights, activations and results
ADDR_W, 8, width of all memory addresses
ACC_W, 24, signed accumulator width (must be at least 2*DATA_W)
FRAC_BITS, 4, arithmetic right shift applied to the accumulator before saturation
CNT_W, 8, width of the Nk and Nn descriptor fields

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; descriptor sampled when accepted
nk  in  CNT_W  inputs per neuron
nn  in  CNT_W  neurons in the layer
w_base  in  ADDR_W  weight ROM base address
in_base  in  ADDR_W  DP-RAM base address of the input vector
out_base  in  ADDR_W  DP-RAM base address of the output vector
w_addr  out  ADDR_W  weight ROM read address
n_raddr  out  ADDR_W  DP-RAM read address
w_data  in  DATA_W  weight; valid 1 cycle after w_addr
n_rdata  in  DATA_W  activation; valid 1 cycle after n_raddr
n_waddr  out  ADDR_W  DP-RAM write address
n_wdata  out  DATA_W  DP-RAM write data
n_we  out  1  DP-RAM write strobe
busy  out  1  high from the accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  descriptor error; held until the next accepted start
sat  out  1  sticky; set when any result saturated; cleared on accepted start

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. All outputs and the accumulator clear to 0.
- FSM states: IDLE -> ACCUM -> DRAIN -> WRITE -> (ACCUM for the next neuron | FIN) -> IDLE.
- IDLE: start=1 latches the descriptor, clears err and sat, and sets busy on the next cycle. start is ignored while busy=1.
- If nk==0 or nn==0 at start: go straight to FIN, set err=1, issue no writes.
- ACCUM: lasts nk cycles, index k=0..nk-1.
  - w_addr = w_base + n*nk + k, generated by an incrementing pointer (no multiplier).
  - n_raddr = in_base + k.
  - A valid bit delayed by 1 cycle qualifies the returned data.
  - Accumulate: acc += sign-extended product (w_data * n_rdata, full 2*DATA_W signed).
  - The accumulator is cleared at the first valid product of each neuron, not carried over between neurons.
- DRAIN: 1 cycle; accumulates the final product.
- WRITE: 1 cycle.
  - n_we=1, n_waddr = out_base + n.
  - n_wdata = sat(acc >>> FRAC_BITS) to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Clipping sets sat.
  - n increments; if n==nn go to FIN, else back to ACCUM.
- Cycles per neuron: nk+2. First n_we occurs nk+2 cycles after the accepted start edge.
- FIN: done=1 for 1 cycle, busy falls in the same cycle, return to IDLE. Total latency start -> done is nn*(nk+2)+1 cycles.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
- Accumulator overflow beyond ACC_W wraps; sizing ACC_W is the integrator's responsibility.
- start in the same cycle as done is accepted (back-to-back layers).
- A mid-operation reset aborts immediately. No partial write is completed after reset asserts; the FSM restarts in IDLE.
- n_we is never asserted outside WRITE.

Optional Feature:
RELU_EN
- Defined: n_wdata = max(0, saturated result); negative results write 0 and do not set sat.
- Undefined: signed saturated result is written unchanged.

Decomposition:
- Shared package: FSM state encoding (IDLE, ACCUM, DRAIN, WRITE, FIN), default width constants, and the saturate/rescale function, for reuse by later multi-layer sequencers.
- One natural sub-module: nle_mac. It is the registered multiply-accumulate with clear/enable plus the rescale/saturate output stage; the FSM and address generation stay in the top level.

Test Plan:
- Reset held low, then released with start=0 -> all outputs 0, busy=0, no n_we for 20 cycles.
- nk=4, nn=1, FRAC_BITS=0, weights 1,2,3,4, inputs 1,1,1,1:
  - first n_we at cycle 6 with n_wdata=10, n_waddr=out_base.
  - done at cycle 7.
- nk=2, nn=3, weights all 127, inputs 127 -> each result saturates to 127, sat=1, three writes at out_base..out_base+2, done after 13 cycles.
- Negative sum -200 with FRAC_BITS=0:
  - RELU_EN undefined: writes -128 with sat=1.
  - RELU_EN defined: writes 0 with sat=0.
- nk=0, nn=5 -> err=1, done 1 cycle after busy, zero writes. Then start with nk=1, nn=1 -> err clears.
- reset pulled low at the 3rd ACCUM cycle -> busy and n_we drop asynchronously. A new start then runs to completion with correct results; in_base=0xFE with nk=4 wraps n_raddr to 0xFE, 0xFF, 0x00, 0x01.

Source files
------------

// File: rtl/neural_layer_engine_pkg.sv
// Shared types, default widths and the rescale/saturate helper for the layer engine
// and any later multi-layer sequencer built around it.
package neural_layer_engine_pkg;

    localparam int DEF_DATA_W    = 32'd8;
    localparam int DEF_ADDR_W    = 32'd8;
    localparam int DEF_ACC_W     = 32'd24;
    localparam int DEF_FRAC_BITS = 32'd4;
    localparam int DEF_CNT_W     = 32'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               clip;
    } sat_res_t;

    // Arithmetic shift by frac_bits, then clamp into the signed data_w range.
    function automatic sat_res_t rescale_sat(input logic signed [63:0] acc,
                                             input int frac_bits,
                                             input int data_w);
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        shifted = acc >>> frac_bits;
        hi      = (64'sd1 <<< (data_w - 32'sd1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        if (shifted > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (shifted < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end else begin
            r.val  = shifted;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nle_mac.sv
// Registered signed multiply-accumulate with clear/enable and the rescale/saturate
// output stage. Build option: RELU_EN clamps negative results to zero.
module nle_mac
    import neural_layer_engine_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result,
    output logic                     clip
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    acc_r;
    sat_res_t                   rs_s;
    logic                       unused_hi_s;

    assign prod_s      = a * b;
    assign prod_ext_s  = ACC_W'(prod_s);
    assign unused_hi_s = ^rs_s.val[63:DATA_W];

    // Accumulator: a clear restarts the sum with the current product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= clr ? prod_ext_s : acc_r + prod_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Rescale and clamp the running sum into the output data range.
    always_comb begin
        rs_s   = rescale_sat(64'(acc_r), FRAC_BITS, DATA_W);
        result = rs_s.val[DATA_W-1:0];
        clip   = rs_s.clip;
`ifdef RELU_EN
        if (rs_s.val[63]) begin
            result = {DATA_W{1'b0}};
            clip   = 1'b0;
        end else begin
            result = rs_s.val[DATA_W-1:0];
            clip   = rs_s.clip;
        end
`endif
    end

endmodule

// File: rtl/neural_layer_engine.sv
// One fully-connected layer: address sequencing, MAC control and saturated write-back.
// Build option: RELU_EN (non-negative outputs, handled inside nle_mac).
module neural_layer_engine
    import neural_layer_engine_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  nk,
    input  logic [CNT_W-1:0]  nn,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] n_raddr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] n_rdata,
    output logic [ADDR_W-1:0] n_waddr,
    output logic [DATA_W-1:0] n_wdata,
    output logic              n_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sat
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

    state_t              state_r, next_s;
    logic [CNT_W-1:0]    nk_r, nn_r, k_r, n_r;
    logic [ADDR_W-1:0]   in_base_r, out_base_r;
    logic                valid_r, first_r;
    logic                k_last_s, n_last_s, desc_bad_s;
    logic [DATA_W-1:0]   mac_res_s;
    logic                mac_clip_s;

    assign k_last_s   = (k_r == nk_r - CNT_ONE);
    assign n_last_s   = (n_r == nn_r - CNT_ONE);
    assign desc_bad_s = (nk == {CNT_W{1'b0}}) || (nn == {CNT_W{1'b0}});

    nle_mac #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk    (clk),
        .rst_n  (reset),
        .en     (valid_r),
        .clr    (first_r),
        .a      (w_data),
        .b      (n_rdata),
        .result (mac_res_s),
        .clip   (mac_clip_s)
    );

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = desc_bad_s ? ST_FIN : ST_ACCUM;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ACCUM: next_s = k_last_s ? ST_DRAIN : ST_ACCUM;
            ST_DRAIN: next_s = ST_WRITE;
            ST_WRITE: next_s = n_last_s ? ST_FIN : ST_ACCUM;
            ST_FIN:   next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // State register, counters, address pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            nk_r       <= {CNT_W{1'b0}};
            nn_r       <= {CNT_W{1'b0}};
            k_r        <= {CNT_W{1'b0}};
            n_r        <= {CNT_W{1'b0}};
            in_base_r  <= {ADDR_W{1'b0}};
            out_base_r <= {ADDR_W{1'b0}};
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            w_addr     <= {ADDR_W{1'b0}};
            n_raddr    <= {ADDR_W{1'b0}};
            n_waddr    <= {ADDR_W{1'b0}};
            n_wdata    <= {DATA_W{1'b0}};
            n_we       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state_r <= next_s;
            busy    <= (next_s != ST_IDLE);
            done    <= (state_r == ST_FIN);
            n_we    <= 1'b0;
            // Returned data lags the address by one cycle, so does its qualifier.
            valid_r <= (state_r == ST_ACCUM);
            first_r <= (state_r == ST_ACCUM) && (k_r == {CNT_W{1'b0}});
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nk_r       <= nk;
                        nn_r       <= nn;
                        in_base_r  <= in_base;
                        out_base_r <= out_base;
                        w_addr     <= w_base;
                        n_raddr    <= in_base;
                        k_r        <= {CNT_W{1'b0}};
                        n_r        <= {CNT_W{1'b0}};
                        err        <= desc_bad_s;
                        sat        <= 1'b0;
                    end else begin
                        w_addr <= w_addr;
                    end
                end
                ST_ACCUM: begin
                    // Weight pointer runs on across neurons: w_base + n*nk + k.
                    w_addr  <= w_addr + ADDR_ONE;
                    k_r     <= k_last_s ? {CNT_W{1'b0}} : k_r + CNT_ONE;
                    n_raddr <= k_last_s ? in_base_r : n_raddr + ADDR_ONE;
                end
                ST_WRITE: begin
                    n_we    <= 1'b1;
                    n_waddr <= out_base_r + ADDR_W'(n_r);
                    n_wdata <= mac_res_s;
                    sat     <= sat | mac_clip_s;
                    n_r     <= n_r + CNT_ONE;
                end
                default: begin
                    n_r <= n_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed self-checking bench for neural_layer_engine with synchronous ROM/RAM models.
module tb_neural_layer_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] nk, nn, w_base, in_base, out_base;
    logic [7:0] w_addr, n_raddr, w_data, n_rdata, n_waddr, n_wdata;
    logic       n_we, busy, done, err, sat;

    logic [7:0] rom [256];
    logic [7:0] ram [256];

    int n_checks = 0;
    int n_fail   = 0;
    int first_we, done_c;
    logic busy0;
    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];
    logic [7:0] raddr_log [8];

    neural_layer_engine #(
        .DATA_W(8), .ADDR_W(8), .ACC_W(24), .FRAC_BITS(0), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .nk(nk), .nn(nn),
        .w_base(w_base), .in_base(in_base), .out_base(out_base),
        .w_addr(w_addr), .n_raddr(n_raddr), .w_data(w_data), .n_rdata(n_rdata),
        .n_waddr(n_waddr), .n_wdata(n_wdata), .n_we(n_we),
        .busy(busy), .done(done), .err(err), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data  <= rom[w_addr];
        n_rdata <= ram[n_raddr];
    end

    // Called at a negedge; holds start across exactly one rising edge.
    task automatic start_layer(input logic [7:0] k, input logic [7:0] n,
                               input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob);
        nk = k; nn = n; w_base = wb; in_base = ib; out_base = ob;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int poke_c);
        first_we = -1; done_c = -1; busy0 = 1'b0;
        wq_addr.delete(); wq_data.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c < 8) raddr_log[c] = n_raddr;
            if (c == 0) busy0 = busy;
            if (c == poke_c) begin start = 1'b1; nk = 8'd0; end
            else start = 1'b0;
            if (n_we) begin
                if (first_we < 0) first_we = c;
                wq_addr.push_back(n_waddr);
                wq_data.push_back(n_wdata);
            end
            if (done) begin done_c = c; break; end
        end
        start = 1'b0;
        n_checks++;
        if (done_c < 0) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
    endtask

    task automatic test_reset;
        int bad = 0;
        reset = 1'b0; start = 1'b0;
        nk = 8'd0; nn = 8'd0; w_base = 8'd0; in_base = 8'd0; out_base = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({w_addr, n_raddr, n_waddr, n_wdata, n_we, busy, done, err, sat} !== 37'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0",
                {w_addr, n_raddr, n_waddr, n_wdata, n_we, busy, done, err, sat});
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
    endtask

    task automatic test_basic_dot;
        rom[8'h10] = 8'd1; rom[8'h11] = 8'd2; rom[8'h12] = 8'd3; rom[8'h13] = 8'd4;
        for (int i = 0; i < 4; i++) ram[8'h20 + i] = 8'd1;
        start_layer(8'd4, 8'd1, 8'h10, 8'h20, 8'h80);
        run_until_done(40, -1);
        n_checks++;
        if (first_we != 6) begin n_fail++; $display("FAIL basic_we_cycle: got %0d want 6", first_we); end
        n_checks++;
        if (done_c != 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 7", done_c); end
        n_checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 8'h80 || wq_data[0] !== 8'd10) begin
            n_fail++; $display("FAIL basic_write: n=%0d addr=%h data=%h want 1/80/0a",
                wq_addr.size(), wq_addr[0], wq_data[0]);
        end
        n_checks++;
        if (busy !== 1'b0 || sat !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL basic_flags: busy=%b sat=%b err=%b want 000", busy, sat, err);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 6; i++) rom[8'h30 + i] = 8'd127;
        ram[8'h40] = 8'd127; ram[8'h41] = 8'd127;
        start_layer(8'd2, 8'd3, 8'h30, 8'h40, 8'h90);
        run_until_done(40, 3);
        n_checks++;
        if (done_c != 13) begin n_fail++; $display("FAIL sat_done_cycle: got %0d want 13", done_c); end
        n_checks++;
        if (wq_addr.size() != 3) begin
            n_fail++; $display("FAIL sat_write_count: got %0d want 3", wq_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wq_addr[i] !== 8'h90 + i[7:0] || wq_data[i] !== 8'h7f) begin
                    n_fail++; $display("FAIL sat_write%0d: addr=%h data=%h want %h/7f",
                        i, wq_addr[i], wq_data[i], 8'h90 + i[7:0]);
                end
            end
        end
        n_checks++;
        if (sat !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL sat_flag: sat=%b err=%b want 1/0 (busy start ignored)", sat, err);
        end
    endtask

    task automatic test_multi_neuron;
        rom[8'h50] = 8'd1; rom[8'h51] = 8'd2; rom[8'h52] = 8'd3; rom[8'h53] = 8'd4;
        ram[8'h58] = 8'd5; ram[8'h59] = 8'd6;
        start_layer(8'd2, 8'd2, 8'h50, 8'h58, 8'hA0);
        run_until_done(40, -1);
        n_checks++;
        if (wq_addr.size() != 2 || wq_data[0] !== 8'd17 || wq_data[1] !== 8'd39
            || wq_addr[1] !== 8'hA1) begin
            n_fail++; $display("FAIL multi_results: n=%0d d0=%h d1=%h a1=%h want 2/11/27/a1",
                wq_addr.size(), wq_data[0], wq_data[1], wq_addr[1]);
        end
        n_checks++;
        if (sat !== 1'b0 || done_c != 9) begin
            n_fail++; $display("FAIL multi_flags: sat=%b done=%0d want 0/9", sat, done_c);
        end
    endtask

    task automatic test_negative;
        logic [7:0] exp_d;
        logic       exp_s;
`ifdef RELU_EN
        exp_d = 8'h00; exp_s = 1'b0;
`else
        exp_d = 8'h80; exp_s = 1'b1;
`endif
        rom[8'h60] = 8'h9C; rom[8'h61] = 8'h9C;
        ram[8'h68] = 8'd1;  ram[8'h69] = 8'd1;
        start_layer(8'd2, 8'd1, 8'h60, 8'h68, 8'hB0);
        run_until_done(40, -1);
        n_checks++;
        if (wq_data.size() != 1 || wq_data[0] !== exp_d || sat !== exp_s) begin
            n_fail++; $display("FAIL negative_sum: data=%h sat=%b want %h/%b",
                wq_data[0], sat, exp_d, exp_s);
        end
    endtask

    task automatic test_desc_error;
        start_layer(8'd0, 8'd5, 8'h00, 8'h00, 8'hC0);
        run_until_done(20, -1);
        n_checks++;
        if (busy0 !== 1'b1 || done_c != 1 || err !== 1'b1 || wq_addr.size() != 0) begin
            n_fail++; $display("FAIL desc_error: busy0=%b done=%0d err=%b writes=%0d want 1/1/1/0",
                busy0, done_c, err, wq_addr.size());
        end
        rom[8'h74] = 8'd3; ram[8'h7C] = 8'hFE;
        start_layer(8'd1, 8'd1, 8'h74, 8'h7C, 8'hC4);
        run_until_done(20, -1);
        n_checks++;
`ifdef RELU_EN
        if (err !== 1'b0 || wq_data.size() != 1 || wq_data[0] !== 8'h00) begin
`else
        if (err !== 1'b0 || wq_data.size() != 1 || wq_data[0] !== 8'hFA) begin
`endif
            n_fail++; $display("FAIL err_recover: err=%b data=%h", err, wq_data[0]);
        end
    endtask

    task automatic test_back_to_back;
        rom[8'h80] = 8'd2; rom[8'h81] = 8'hFD; rom[8'h82] = 8'd5;
        ram[8'h88] = 8'd4; ram[8'h89] = 8'd1; ram[8'h8A] = 8'hFE;
        rom[8'h84] = 8'd7; ram[8'h8C] = 8'd6;
        start_layer(8'd3, 8'd1, 8'h80, 8'h88, 8'hD8);
        run_until_done(40, -1);
        n_checks++;
`ifdef RELU_EN
        if (wq_data.size() != 1 || wq_data[0] !== 8'h00 || sat !== 1'b0) begin
`else
        if (wq_data.size() != 1 || wq_data[0] !== 8'hFB || sat !== 1'b0) begin
`endif
            n_fail++; $display("FAIL b2b_first: data=%h sat=%b", wq_data[0], sat);
        end
        start_layer(8'd1, 8'd1, 8'h84, 8'h8C, 8'hDC);
        run_until_done(20, -1);
        n_checks++;
        if (done_c != 4 || wq_data.size() != 1 || wq_data[0] !== 8'd42 || wq_addr[0] !== 8'hDC) begin
            n_fail++; $display("FAIL b2b_second: done=%0d data=%h addr=%h want 4/2a/dc",
                done_c, wq_data[0], wq_addr[0]);
        end
    endtask

    task automatic test_abort_and_wrap;
        int bad = 0;
        start_layer(8'd4, 8'd1, 8'h10, 8'h20, 8'hE0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || n_we !== 1'b0 || w_addr !== 8'h00) begin
            n_fail++; $display("FAIL abort_async: busy=%b n_we=%b w_addr=%h want 0/0/00", busy, n_we, w_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (n_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_no_write: %0d active cycles, want 0", bad); end
        rom[8'h08] = 8'd1; rom[8'h09] = 8'd1; rom[8'h0A] = 8'd2; rom[8'h0B] = 8'd1;
        ram[8'hFE] = 8'd3; ram[8'hFF] = 8'hFF; ram[8'h00] = 8'd2; ram[8'h01] = 8'd5;
        start_layer(8'd4, 8'd1, 8'h08, 8'hFE, 8'hE8);
        run_until_done(40, -1);
        n_checks++;
        if (raddr_log[0] !== 8'hFE || raddr_log[1] !== 8'hFF || raddr_log[2] !== 8'h00
            || raddr_log[3] !== 8'h01) begin
            n_fail++; $display("FAIL wrap_raddr: got %h %h %h %h want fe ff 00 01",
                raddr_log[0], raddr_log[1], raddr_log[2], raddr_log[3]);
        end
        n_checks++;
        if (wq_data.size() != 1 || wq_data[0] !== 8'd11 || wq_addr[0] !== 8'hE8 || done_c != 7) begin
            n_fail++; $display("FAIL wrap_result: data=%h addr=%h done=%0d want 0b/e8/7",
                wq_data[0], wq_addr[0], done_c);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'd0;
            ram[i] = 8'd0;
        end
        test_reset();
        test_basic_dot();
        test_saturation();
        test_multi_neuron();
        test_negative();
        test_desc_error();
        test_back_to_back();
        test_abort_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
